// File: rtl/rv64_decode_stage_if.sv
// Bundle between the IF/ID register, writeback and the decode stage, plus the
// ID/EX outputs and the early fetch redirect.
interface rv64_decode_stage_if;
    logic [31:0] InstrD;
    logic [63:0] PCD;
    logic [63:0] PCPlus4D;
    logic        RegWriteEnW;
    logic [4:0]  RDW;
    logic [63:0] ResultW;

    logic        RegWriteEnE;
    logic        MemtoRegE;
    logic        JALE;
    logic        MemReadEnE;
    logic        MemWriteEnE;
    logic        ALUSrcE;
    logic [2:0]  ALUOpE;
    logic [1:0]  MemSizeE;
    logic [1:0]  LoadSizeE;
    logic [4:0]  RdE;
    logic [63:0] ImmE;
    logic [63:0] ReadData1E;
    logic [63:0] ReadData2E;
    logic [63:0] PCPlus4E;
    logic        PCSF;
    logic [63:0] PCTargetD;

    // Decode stage side
    modport master (
        input  InstrD, PCD, PCPlus4D, RegWriteEnW, RDW, ResultW,
        output RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE,
        output ALUOpE, MemSizeE, LoadSizeE, RdE, ImmE, ReadData1E, ReadData2E,
        output PCPlus4E, PCSF, PCTargetD
    );

    // Fetch / execute / writeback side
    modport slave (
        output InstrD, PCD, PCPlus4D, RegWriteEnW, RDW, ResultW,
        input  RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE,
        input  ALUOpE, MemSizeE, LoadSizeE, RdE, ImmE, ReadData1E, ReadData2E,
        input  PCPlus4E, PCSF, PCTargetD
    );
endinterface

// File: rtl/rv64_decode_stage.sv
// RV64 instruction-decode stage: register file with write-through bypass,
// control/immediate decode, early branch/jump resolution and the ID/EX register.
module rv64_decode_stage (
    input  logic clk,
    input  logic rst,
    rv64_decode_stage_if.master bus
);
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic [2:0] aluFromFunct3(input logic [2:0] f3);
        logic [2:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b001:  op = ALU_SLL;
            3'b101:  op = ALU_SRL;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [63:0] regFile [32];
    logic [63:0] readData1;
    logic [63:0] readData2;
    logic [63:0] immD;
    logic [63:0] jalrTarget;

    logic        regWriteD;
    logic        memtoRegD;
    logic        jalD;
    logic        memReadD;
    logic        memWriteD;
    logic        aluSrcD;
    logic [2:0]  aluOpD;
    logic [1:0]  memSizeD;
    logic [1:0]  loadSizeD;
    logic        branchTaken;

    assign opcode  = bus.InstrD[6:0];
    assign funct3  = bus.InstrD[14:12];
    assign funct7  = bus.InstrD[31:25];
    // LUI has no rs1; its [19:15] bits belong to the immediate.
    assign rs1Addr = (opcode == OPC_LUI) ? 5'd0 : bus.InstrD[19:15];
    assign rs2Addr = bus.InstrD[24:20];

    // Register file write port; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= 64'd0;
            end
        end else if (bus.RegWriteEnW && (bus.RDW != 5'd0)) begin
            regFile[bus.RDW] <= bus.ResultW;
        end else begin
            regFile[0] <= 64'd0;
        end
    end

    // Read ports with write-through bypass from writeback.
    always_comb begin
        readData1 = 64'd0;
        readData2 = 64'd0;
        if (rs1Addr == 5'd0) begin
            readData1 = 64'd0;
        end else if (bus.RegWriteEnW && (bus.RDW == rs1Addr)) begin
            readData1 = bus.ResultW;
        end else begin
            readData1 = regFile[rs1Addr];
        end
        if (rs2Addr == 5'd0) begin
            readData2 = 64'd0;
        end else if (bus.RegWriteEnW && (bus.RDW == rs2Addr)) begin
            readData2 = bus.ResultW;
        end else begin
            readData2 = regFile[rs2Addr];
        end
    end

    // Control and immediate decode; unknown opcodes decode to a bubble.
    always_comb begin
        regWriteD = 1'b0;
        memtoRegD = 1'b0;
        jalD      = 1'b0;
        memReadD  = 1'b0;
        memWriteD = 1'b0;
        aluSrcD   = 1'b0;
        aluOpD    = ALU_ADD;
        memSizeD  = 2'b00;
        loadSizeD = 2'b00;
        immD      = 64'd0;
        case (opcode)
            OPC_R: begin
                regWriteD = 1'b1;
                aluOpD    = ((funct3 == 3'b000) && (funct7 == 7'b0100000)) ? ALU_SUB
                                                                          : aluFromFunct3(funct3);
            end
            OPC_I: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluOpD    = aluFromFunct3(funct3);
                immD      = {{52{bus.InstrD[31]}}, bus.InstrD[31:20]};
            end
            OPC_LOAD: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                memReadD  = 1'b1;
                memtoRegD = 1'b1;
                loadSizeD = funct3[1:0];
                immD      = {{52{bus.InstrD[31]}}, bus.InstrD[31:20]};
            end
            OPC_STORE: begin
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
                memSizeD  = funct3[1:0];
                immD      = {{52{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            end
            OPC_BRANCH: begin
                aluOpD = ALU_SUB;
                immD   = {{52{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                          bus.InstrD[11:8], 1'b0};
            end
            OPC_JAL: begin
                regWriteD = 1'b1;
                jalD      = 1'b1;
                aluSrcD   = 1'b1;
                immD      = {{44{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20],
                             bus.InstrD[30:21], 1'b0};
            end
            OPC_JALR: begin
                regWriteD = 1'b1;
                jalD      = 1'b1;
                aluSrcD   = 1'b1;
                immD      = {{52{bus.InstrD[31]}}, bus.InstrD[31:20]};
            end
            OPC_LUI: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                immD      = {{32{bus.InstrD[31]}}, bus.InstrD[31:12], 12'd0};
            end
            default: begin
                regWriteD = 1'b0;
            end
        endcase
    end

    // Only BEQ and BNE resolve here; other branch funct3 values never redirect.
    always_comb begin
        branchTaken = 1'b0;
        if (opcode == OPC_BRANCH) begin
            case (funct3)
                3'b000:  branchTaken = (readData1 == readData2);
                3'b001:  branchTaken = (readData1 != readData2);
                default: branchTaken = 1'b0;
            endcase
        end else begin
            branchTaken = 1'b0;
        end
    end

    assign jalrTarget    = (readData1 + immD) & ~64'd1;
    assign bus.PCTargetD = (opcode == OPC_JALR) ? jalrTarget : (bus.PCD + immD);
    assign bus.PCSF      = (opcode == OPC_JAL) | (opcode == OPC_JALR) | branchTaken;

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWriteEnE <= 1'b0;
            bus.MemtoRegE   <= 1'b0;
            bus.JALE        <= 1'b0;
            bus.MemReadEnE  <= 1'b0;
            bus.MemWriteEnE <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ALUOpE      <= 3'd0;
            bus.MemSizeE    <= 2'd0;
            bus.LoadSizeE   <= 2'd0;
            bus.RdE         <= 5'd0;
            bus.ImmE        <= 64'd0;
            bus.ReadData1E  <= 64'd0;
            bus.ReadData2E  <= 64'd0;
            bus.PCPlus4E    <= 64'd0;
        end else begin
            bus.RegWriteEnE <= regWriteD;
            bus.MemtoRegE   <= memtoRegD;
            bus.JALE        <= jalD;
            bus.MemReadEnE  <= memReadD;
            bus.MemWriteEnE <= memWriteD;
            bus.ALUSrcE     <= aluSrcD;
            bus.ALUOpE      <= aluOpD;
            bus.MemSizeE    <= memSizeD;
            bus.LoadSizeE   <= loadSizeD;
            bus.RdE         <= bus.InstrD[11:7];
            bus.ImmE        <= immD;
            bus.ReadData1E  <= readData1;
            bus.ReadData2E  <= readData2;
            bus.PCPlus4E    <= bus.PCPlus4D;
        end
    end
endmodule

// File: tb/tb_rv64_decode_stage.sv
// Self-checking bench for rv64_decode_stage: directed cases from the
// instruction-level rules followed by randomized instructions against a model.
module tb_rv64_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv64_decode_stage_if bus();
    rv64_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;

    logic [63:0] mreg [32];
    logic [2:0]  f3Op [8];

    logic        eRw, eM2r, eJal, eMr, eMw, eAsrc, ePcsf;
    logic [2:0]  eOp;
    logic [1:0]  eMs, eLs;
    logic [4:0]  eRd;
    logic [63:0] eImm, eR1, eR2, eP4, eTgt;
    logic        pendWe;
    logic [4:0]  pendRd;
    logic [63:0] pendRes;

    localparam logic [31:0] NOP = 32'h00000013;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(input longint raw, input int bits);
        longint half;
        half = longint'(1) <<< (bits - 1);
        return (raw >= half) ? raw - (half * 2) : raw;
    endfunction

    function automatic logic [63:0] modelRead(input logic [4:0] r, input logic we,
                                              input logic [4:0] wr, input logic [63:0] wd);
        if (r == 5'd0) return 64'd0;
        if (we && wr == r) return wd;
        return mreg[r];
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [63:0] pcd,
                         input logic we, input logic [4:0] rdw, input logic [63:0] res);
        longint iImm, sImm, bImm, jImm, uImm;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rs1;
        bus.InstrD = instr; bus.PCD = pcd; bus.PCPlus4D = pcd + 64'd4;
        bus.RegWriteEnW = we; bus.RDW = rdw; bus.ResultW = res;
        op = instr[6:0];
        f3 = instr[14:12];
        iImm = sext(longint'(instr[31:20]), 12);
        sImm = sext(longint'({instr[31:25], instr[11:7]}), 12);
        bImm = sext(longint'({instr[31], instr[7], instr[30:25], instr[11:8]}), 12) * 2;
        jImm = sext(longint'({instr[31], instr[19:12], instr[20], instr[30:21]}), 20) * 2;
        uImm = sext(longint'(instr[31:12]), 20) * 4096;
        rs1 = (op == 7'h37) ? 5'd0 : instr[19:15];
        eR1 = modelRead(rs1, we, rdw, res);
        eR2 = modelRead(instr[24:20], we, rdw, res);
        eRd = instr[11:7];
        eP4 = pcd + 64'd4;
        {eRw, eM2r, eJal, eMr, eMw, eAsrc} = 6'b0;
        eOp = 3'd0; eMs = 2'd0; eLs = 2'd0; eImm = 64'd0;
        case (op)
            7'h33: begin eRw = 1'b1; eOp = (f3 == 3'd0 && instr[31:25] == 7'h20) ? 3'd1 : f3Op[f3]; end
            7'h13: begin eRw = 1'b1; eAsrc = 1'b1; eOp = f3Op[f3]; eImm = iImm; end
            7'h03: begin eRw = 1'b1; eAsrc = 1'b1; eMr = 1'b1; eM2r = 1'b1; eLs = f3[1:0]; eImm = iImm; end
            7'h23: begin eAsrc = 1'b1; eMw = 1'b1; eMs = f3[1:0]; eImm = sImm; end
            7'h63: begin eOp = 3'd1; eImm = bImm; end
            7'h6F: begin eRw = 1'b1; eJal = 1'b1; eAsrc = 1'b1; eImm = jImm; end
            7'h67: begin eRw = 1'b1; eJal = 1'b1; eAsrc = 1'b1; eImm = iImm; end
            7'h37: begin eRw = 1'b1; eAsrc = 1'b1; eImm = uImm; end
            default: eImm = 64'd0;
        endcase
        eTgt  = (op == 7'h67) ? ((eR1 + eImm) & ~64'd1) : (pcd + eImm);
        ePcsf = (op == 7'h6F) || (op == 7'h67) ||
                (op == 7'h63 && f3 == 3'd0 && eR1 == eR2) ||
                (op == 7'h63 && f3 == 3'd1 && eR1 != eR2);
        pendWe = we; pendRd = rdw; pendRes = res;
        vectors++;
        #1;
        chk("PCSF", bus.PCSF, ePcsf);
        chk("PCTargetD", bus.PCTargetD, eTgt);
    endtask

    task automatic clockE();
        @(posedge clk);
        if (pendWe && pendRd != 5'd0) mreg[pendRd] = pendRes;
        #1;
        chk("RegWriteEnE", bus.RegWriteEnE, eRw);
        chk("MemtoRegE", bus.MemtoRegE, eM2r);
        chk("JALE", bus.JALE, eJal);
        chk("MemReadEnE", bus.MemReadEnE, eMr);
        chk("MemWriteEnE", bus.MemWriteEnE, eMw);
        chk("ALUSrcE", bus.ALUSrcE, eAsrc);
        chk("ALUOpE", bus.ALUOpE, eOp);
        chk("MemSizeE", bus.MemSizeE, eMs);
        chk("LoadSizeE", bus.LoadSizeE, eLs);
        chk("RdE", bus.RdE, eRd);
        chk("ImmE", bus.ImmE, eImm);
        chk("ReadData1E", bus.ReadData1E, eR1);
        chk("ReadData2E", bus.ReadData2E, eR2);
        chk("PCPlus4E", bus.PCPlus4E, eP4);
    endtask

    task automatic step(input logic [31:0] instr, input logic [63:0] pcd,
                        input logic we, input logic [4:0] rdw, input logic [63:0] res);
        drive(instr, pcd, we, rdw, res);
        clockE();
    endtask

    task automatic checkZeroE(input string tag);
        chk({tag, " ctl"}, {58'd0, bus.RegWriteEnE, bus.MemtoRegE, bus.JALE,
                            bus.MemReadEnE, bus.MemWriteEnE, bus.ALUSrcE}, 64'd0);
        chk({tag, " fields"}, {50'd0, bus.ALUOpE, bus.MemSizeE, bus.LoadSizeE, bus.RdE}, 64'd0);
        chk({tag, " ImmE"}, bus.ImmE, 64'd0);
        chk({tag, " ReadData1E"}, bus.ReadData1E, 64'd0);
        chk({tag, " ReadData2E"}, bus.ReadData2E, 64'd0);
        chk({tag, " PCPlus4E"}, bus.PCPlus4E, 64'd0);
    endtask

    function automatic bit isListed(input logic [6:0] o);
        return o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 ||
               o == 7'h63 || o == 7'h6F || o == 7'h67 || o == 7'h37;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  opcs [8];
        logic [31:0] instr;
        logic [6:0]  o;
        logic [4:0]  rdw;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
        f3Op = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};
        for (int i = 0; i < 32; i++) mreg[i] = 64'd0;

        // Reset: redirect still follows inputs, ID/EX stays cleared
        rst = 1'b0;
        drive(32'h001000EF, 64'h18, 1'b1, 5'd1, 64'h55);
        @(posedge clk); #1;
        checkZeroE("reset1");
        @(posedge clk); #1;
        checkZeroE("reset2");
        rst = 1'b1;

        // Registers read zero after reset
        step(32'h007372B3, 64'h0, 1'b0, 5'd0, 64'd0);
        chk("and ALUOpE", bus.ALUOpE, 64'd2);
        chk("and rs1 after reset", bus.ReadData1E, 64'd0);

        // Write x1 = 15, then addi x4,x1,5
        step(NOP, 64'h0, 1'b1, 5'd1, 64'd15);
        step(32'h00508213, 64'h4, 1'b0, 5'd0, 64'd0);
        chk("addi ImmE", bus.ImmE, 64'd5);
        chk("addi ReadData1E", bus.ReadData1E, 64'd15);
        chk("addi ALUSrcE", bus.ALUSrcE, 64'd1);
        chk("addi RegWriteEnE", bus.RegWriteEnE, 64'd1);
        chk("addi ALUOpE", bus.ALUOpE, 64'd0);
        chk("addi RdE", bus.RdE, 64'd4);

        step(NOP, 64'h0, 1'b1, 5'd2, 64'd7);
        step(NOP, 64'h0, 1'b1, 5'd3, 64'd7);
        step(32'h40C106B3, 64'h8, 1'b1, 5'd12, 64'd3);
        chk("sub ALUOpE", bus.ALUOpE, 64'd1);
        chk("sub ALUSrcE", bus.ALUSrcE, 64'd0);

        // BEQ taken / not taken / taken through bypass
        drive(32'h00310263, 64'h10, 1'b0, 5'd0, 64'd0);
        chk("beq taken PCSF", bus.PCSF, 64'd1);
        chk("beq PCTargetD", bus.PCTargetD, 64'h14);
        clockE();
        chk("beq RegWriteEnE", bus.RegWriteEnE, 64'd0);
        step(NOP, 64'h0, 1'b1, 5'd3, 64'd9);
        drive(32'h00310263, 64'h10, 1'b0, 5'd0, 64'd0);
        chk("beq not taken PCSF", bus.PCSF, 64'd0);
        clockE();
        drive(32'h00310263, 64'h10, 1'b1, 5'd3, 64'd7);
        chk("beq bypass PCSF", bus.PCSF, 64'd1);
        clockE();

        // JALR / JAL
        drive(32'h002081E7, 64'h20, 1'b0, 5'd0, 64'd0);
        chk("jalr PCTargetD", bus.PCTargetD, 64'h10);
        chk("jalr PCSF", bus.PCSF, 64'd1);
        clockE();
        chk("jalr JALE", bus.JALE, 64'd1);
        chk("jalr PCPlus4E", bus.PCPlus4E, 64'h24);
        drive(32'h001000EF, 64'h18, 1'b0, 5'd0, 64'd0);
        chk("jal PCTargetD", bus.PCTargetD, 64'h818);
        clockE();

        // Memory and LUI
        step(32'h00309203, 64'h30, 1'b0, 5'd0, 64'd0);
        chk("lh MemReadEnE", bus.MemReadEnE, 64'd1);
        chk("lh MemtoRegE", bus.MemtoRegE, 64'd1);
        chk("lh LoadSizeE", bus.LoadSizeE, 64'd1);
        chk("lh ImmE", bus.ImmE, 64'd3);
        step(32'h00B12623, 64'h34, 1'b0, 5'd0, 64'd0);
        chk("sw MemWriteEnE", bus.MemWriteEnE, 64'd1);
        chk("sw MemSizeE", bus.MemSizeE, 64'd2);
        chk("sw ImmE", bus.ImmE, 64'd12);
        chk("sw RegWriteEnE", bus.RegWriteEnE, 64'd0);
        step(32'h000010B7, 64'h38, 1'b0, 5'd0, 64'd0);
        chk("lui ImmE", bus.ImmE, 64'h1000);
        chk("lui ReadData1E", bus.ReadData1E, 64'd0);
        step(32'h000110B7, 64'h3C, 1'b0, 5'd0, 64'd0);
        chk("lui rs1 forced", bus.ReadData1E, 64'd0);

        // Writes to x0 are dropped, including on the bypass path
        step(32'h00000213, 64'h40, 1'b1, 5'd0, 64'hDEAD);
        chk("x0 bypass", bus.ReadData1E, 64'd0);
        step(32'h00000213, 64'h44, 1'b0, 5'd0, 64'd0);
        chk("x0 after write", bus.ReadData1E, 64'd0);

        // Randomized instructions against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 8) == 0) begin
                do o = 7'($urandom_range(0, 127)); while (isListed(o));
            end else begin
                o = opcs[$urandom_range(0, 7)];
            end
            instr = {$urandom} & 32'hFFFF_FF80;
            instr[6:0] = o;
            if (o == 7'h63) begin
                instr[14:12] = 3'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) instr[24:20] = instr[19:15];
            end
            rdw = ($urandom_range(0, 2) == 0) ? instr[19:15] : 5'($urandom);
            step(instr, {$urandom, $urandom}, 1'($urandom), rdw, {$urandom, $urandom});
        end

        // Asynchronous reset mid-run clears ID/EX and the register file
        #2;
        rst = 1'b0;
        #1;
        checkZeroE("async reset");
        for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int r = 1; r < 32; r += 5) begin
            instr = 32'h00000033;
            instr[19:15] = 5'(r);
            instr[24:20] = 5'(r + 1);
            step(instr, 64'h100, 1'b0, 5'd0, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
